clock_group_sequencer: RTL and testbench

Parametrised clock-group node for the subsystem clock tree. It passes one input clock to N member domains and drives a per-member reset and clock-enable. After boot it releases the member resets in a staggered order. It also runs software-requested per-member reset cycles (gate clock, assert reset, hold, re-enable clock, staggered release) through a valid/ready handshake. It sits where the single-member pass-through clock group sat, between the subsystem clock source and the bus/tile domains.

---
 rtl/clock_group_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_clock_group_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_group_sequencer.sv
// Clock-group node: passes the source clock to N member domains, releases
// member resets one at a time after boot, and runs software-requested
// per-member reset cycles (gate clock, assert reset, hold, re-enable clock,
// staggered release).
module clock_group_sequencer #(
    parameter int N_MEMBERS   = 4,
    parameter int SYNC_STAGES = 2,
    parameter int GAP_CYCLES  = 8,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    output logic                 auto_out_clock,
    output logic [N_MEMBERS-1:0] member_reset,
    output logic [N_MEMBERS-1:0] member_clk_en,
    input  logic                 soft_req_valid,
    input  logic [N_MEMBERS-1:0] soft_req_mask,
    output logic                 soft_req_ready,
    output logic                 soft_done,
    output logic                 all_released,
    output logic [2:0]           fsm_state
);

    localparam int MAX_CYCLES = (GAP_CYCLES > HOLD_CYCLES) ? GAP_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int IDX_W      = (N_MEMBERS > 1) ? $clog2(N_MEMBERS) : 1;

    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_MEMBERS - 1);

    typedef enum logic [2:0] {
        SYNC    = 3'd0,
        RELEASE = 3'd1,
        WAIT    = 3'd2,
        IDLE    = 3'd3,
        GATE    = 3'd4,
        HOLD    = 3'd5
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [IDX_W-1:0]       idx, idx_n;
    logic [CNT_W-1:0]       cnt, cnt_n;
    logic [N_MEMBERS-1:0]   act_mask, mask_n;
    logic [N_MEMBERS-1:0]   mreset_n, clken_n;
    logic                   done_n;
    logic                   soft_active, soft_n;
    logic                   phase, phase_n;

    // The clock itself is never gated here; members gate locally with clk_en.
    assign auto_out_clock = clock;

    // Handshake: a soft request transfers on a rising edge where both
    // soft_req_valid and soft_req_ready are high; soft_req_mask is sampled on
    // that edge. Valid while not ready is dropped, never queued or remembered.
    assign soft_req_ready = (state == IDLE);
    assign all_released   = (state == IDLE);
    assign fsm_state      = state;

    // Reset-deassertion synchroniser: ones while reset is high, then shifts in 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    // State and registered-output update.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= SYNC;
            idx           <= '0;
            cnt           <= '0;
            act_mask      <= '1;
            member_reset  <= '1;
            member_clk_en <= '1;
            soft_done     <= 1'b0;
            soft_active   <= 1'b0;
            phase         <= 1'b0;
        end else begin
            state         <= state_n;
            idx           <= idx_n;
            cnt           <= cnt_n;
            act_mask      <= mask_n;
            member_reset  <= mreset_n;
            member_clk_en <= clken_n;
            soft_done     <= done_n;
            soft_active   <= soft_n;
            phase         <= phase_n;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cnt_n    = cnt;
        mask_n   = act_mask;
        mreset_n = member_reset;
        clken_n  = member_clk_en;
        done_n   = 1'b0;
        soft_n   = soft_active;
        phase_n  = phase;

        case (state)
            SYNC: begin
                if (!sync_q[SYNC_STAGES-1]) begin
                    state_n = RELEASE;
                    idx_n   = '0;
                    mask_n  = '1;
                end
            end

            RELEASE: begin
                // Clock enables are already 1 here, so reset never falls gated.
                if (act_mask[idx]) begin
                    mreset_n[idx] = 1'b0;
                end
                if (idx == LAST_IDX) begin
                    state_n = IDLE;
                    idx_n   = '0;
                    if (soft_active) begin
                        done_n = 1'b1;
                        soft_n = 1'b0;
                    end
                end else if (act_mask[idx] && (GAP_CYCLES != 0)) begin
                    cnt_n   = GAP_LOAD;
                    state_n = WAIT;
                end else begin
                    idx_n = idx + IDX_W'(1);
                end
            end

            WAIT: begin
                // Saturating countdown: leave on 1 so the counter never wraps.
                if (cnt <= CNT_W'(1)) begin
                    cnt_n   = '0;
                    idx_n   = idx + IDX_W'(1);
                    state_n = RELEASE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end

            IDLE: begin
                if (soft_req_valid) begin
                    if (|soft_req_mask) begin
                        mask_n  = soft_req_mask;
                        clken_n = member_clk_en & ~soft_req_mask;
                        soft_n  = 1'b1;
                        phase_n = 1'b0;
                        state_n = GATE;
                    end else begin
                        // Empty request: nothing to do, just acknowledge.
                        done_n = 1'b1;
                    end
                end
            end

            GATE: begin
                // Two cycles of gated clock before reset goes up, so reset
                // always rises while the member clock is stopped.
                if (phase) begin
                    mreset_n = member_reset | act_mask;
                    cnt_n    = HOLD_LOAD;
                    phase_n  = 1'b0;
                    state_n  = HOLD;
                end else begin
                    phase_n = 1'b1;
                end
            end

            HOLD: begin
                // Clock runs during the hold so member logic sees reset clocked.
                clken_n = member_clk_en | act_mask;
                if (cnt <= CNT_W'(1)) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = RELEASE;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end

            default: begin
                state_n = SYNC;
            end
        endcase
    end

endmodule

// File: tb/tb_clock_group_sequencer.sv
// Directed bench for clock_group_sequencer: boot release timing, a masked
// soft reset, an empty request, a request held during boot, reset during
// HOLD, and a single-member no-gap instance.
module tb_clock_group_sequencer;

    localparam logic [2:0] ST_SYNC = 3'd0;
    localparam logic [2:0] ST_IDLE = 3'd3;
    localparam logic [2:0] ST_GATE = 3'd4;
    localparam logic [2:0] ST_HOLD = 3'd5;

    logic       clock;
    logic       reset;
    logic       auto_out_clock;
    logic [3:0] member_reset;
    logic [3:0] member_clk_en;
    logic       soft_req_valid;
    logic [3:0] soft_req_mask;
    logic       soft_req_ready;
    logic       soft_done;
    logic       all_released;
    logic [2:0] fsm_state;

    logic       s_auto_out_clock;
    logic [0:0] s_member_reset;
    logic [0:0] s_member_clk_en;
    logic [0:0] s_soft_req_mask;
    logic       s_soft_req_ready;
    logic       s_soft_done;
    logic       s_all_released;
    logic [2:0] s_fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    int boot_fall[4] = '{4, 8, 12, 16};
    logic [3:0] exp_q[$];

    clock_group_sequencer #(
        .N_MEMBERS(4), .SYNC_STAGES(2), .GAP_CYCLES(3), .HOLD_CYCLES(5)
    ) dut (
        .clock(clock), .reset(reset), .auto_out_clock(auto_out_clock),
        .member_reset(member_reset), .member_clk_en(member_clk_en),
        .soft_req_valid(soft_req_valid), .soft_req_mask(soft_req_mask),
        .soft_req_ready(soft_req_ready), .soft_done(soft_done),
        .all_released(all_released), .fsm_state(fsm_state)
    );

    clock_group_sequencer #(
        .N_MEMBERS(1), .SYNC_STAGES(2), .GAP_CYCLES(0), .HOLD_CYCLES(5)
    ) dut_small (
        .clock(clock), .reset(reset), .auto_out_clock(s_auto_out_clock),
        .member_reset(s_member_reset), .member_clk_en(s_member_clk_en),
        .soft_req_valid(1'b0), .soft_req_mask(s_soft_req_mask),
        .soft_req_ready(s_soft_req_ready), .soft_done(s_soft_done),
        .all_released(s_all_released), .fsm_state(s_fsm_state)
    );

    assign s_soft_req_mask = 1'b0;

    // Clock block
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Boot from reset deassertion: check every edge up to n_edges.
    task automatic run_boot(input int n_edges, input bit with_small);
        logic [3:0] e_rst;
        exp_q.delete();
        for (int e = 1; e <= n_edges; e++) begin
            e_rst = 4'b0000;
            for (int i = 0; i < 4; i++) if (e < boot_fall[i]) e_rst[i] = 1'b1;
            exp_q.push_back(e_rst);
        end
        for (int e = 1; e <= n_edges; e++) begin
            step();
            check("boot_rst", member_reset, exp_q.pop_front());
            check("boot_clken", member_clk_en, 4'hF);
            check("boot_done", soft_done, 1'b0);
            check("boot_ready", soft_req_ready, (e >= 16));
            check("boot_all_rel", all_released, (e >= 16));
            if (with_small) begin
                check("small_rst", s_member_reset, (e < 4));
                check("small_all_rel", s_all_released, (e >= 4));
                check("small_done", s_soft_done, 1'b0);
            end
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rst"}, member_reset, 4'hF);
        check({tag, "_clken"}, member_clk_en, 4'hF);
        check({tag, "_ready"}, soft_req_ready, 1'b0);
        check({tag, "_done"}, soft_done, 1'b0);
        check({tag, "_all_rel"}, all_released, 1'b0);
        check({tag, "_state"}, fsm_state, ST_SYNC);
    endtask

    // Stimulus and final report
    initial begin
        logic [3:0] e_rst;
        logic [3:0] e_clk;

        reset = 1'b1;
        soft_req_valid = 1'b0;
        soft_req_mask = 4'h0;
        repeat (3) step();
        check_reset_values("por");
        check("small_por_rst", s_member_reset, 1'b1);
        check("clk_pass", auto_out_clock, clock);

        // Boot, both instances
        @(negedge clock);
        reset = 1'b0;
        run_boot(20, 1'b1);

        // Soft reset, mask 0101
        @(negedge clock);
        soft_req_valid = 1'b1;
        soft_req_mask = 4'b0101;
        step();
        soft_req_valid = 1'b0;
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) step();
            e_clk = (k < 3) ? 4'b1010 : 4'b1111;
            if (k < 2)       e_rst = 4'b0000;
            else if (k < 8)  e_rst = 4'b0101;
            else if (k < 13) e_rst = 4'b0100;
            else             e_rst = 4'b0000;
            check("soft_clken", member_clk_en, e_clk);
            check("soft_rst", member_reset, e_rst);
            check("soft_done", soft_done, (k == 17));
            check("soft_ready", soft_req_ready, (k >= 17));
        end

        // Empty mask request
        @(negedge clock);
        soft_req_valid = 1'b1;
        soft_req_mask = 4'b0000;
        step();
        soft_req_valid = 1'b0;
        check("zero_state", fsm_state, ST_IDLE);
        check("zero_done", soft_done, 1'b1);
        check("zero_rst", member_reset, 4'h0);
        check("zero_clken", member_clk_en, 4'hF);
        check("zero_ready", soft_req_ready, 1'b1);
        step();
        check("zero_done_end", soft_done, 1'b0);
        check("zero_state_end", fsm_state, ST_IDLE);

        // Request held during boot
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("busy_rst");
        @(negedge clock);
        soft_req_valid = 1'b1;
        soft_req_mask = 4'b0010;
        reset = 1'b0;
        run_boot(16, 1'b0);
        step();
        soft_req_valid = 1'b0;
        check("busy_accept_clken", member_clk_en, 4'b1101);
        check("busy_accept_state", fsm_state, ST_GATE);
        check("busy_accept_ready", soft_req_ready, 1'b0);
        for (int k = 1; k <= 16; k++) begin
            step();
            check("busy_done", soft_done, (k == 14));
            if (k == 14) check("busy_final_rst", member_reset, 4'h0);
        end

        // Reset asserted during HOLD
        @(negedge clock);
        soft_req_valid = 1'b1;
        soft_req_mask = 4'b1111;
        step();
        soft_req_valid = 1'b0;
        step();
        step();
        check("hold_state", fsm_state, ST_HOLD);
        check("hold_rst", member_reset, 4'hF);
        check("hold_clken", member_clk_en, 4'h0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("mid_rst");
        @(negedge clock);
        reset = 1'b0;
        run_boot(20, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
